// File: rtl/mem_sdp_if.sv
// Write/read port bundle for mem_sdp. The master drives requests; the slave (the RAM)
// returns read data, status and the clear-done flag.
interface mem_sdp_if #(
   parameter int dwidth = 32,
   parameter int awidth = 8
);
   localparam int bwidth = dwidth / 8;

   logic              wr;
   logic [awidth-1:0] waddr;
   logic [dwidth-1:0] din;
   logic [bwidth-1:0] be;
   logic              rd;
   logic [awidth-1:0] raddr;
   logic [dwidth-1:0] dout;
   logic              dout_vld;
   logic              init_done;
   logic              par_err;

   modport master (
      output wr, waddr, din, be, rd, raddr,
      input  dout, dout_vld, init_done, par_err
   );

   modport slave (
      input  wr, waddr, din, be, rd, raddr,
      output dout, dout_vld, init_done, par_err
   );
endinterface

// File: rtl/mem_sdp.sv
// Simple-dual-port RAM with byte enables, read bypass, 1/2-cycle read latency and a
// post-reset zero-fill. Optional per-lane even parity is enabled with MEM_PARITY_EN.
module mem_sdp #(
   parameter int dwidth  = 32,
   parameter int awidth  = 8,
   parameter int size    = 256,
   parameter int OUT_REG = 0,
   parameter int BYPASS  = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   mem_sdp_if.slave bus
);
   localparam int bwidth = dwidth / 8;
   localparam int iw     = (size > 1) ? $clog2(size) : 1;
   localparam logic [awidth:0]   size_w = (awidth+1)'(size);
   localparam logic [awidth-1:0] last   = awidth'(size - 1);

   typedef enum logic {INIT, READY} state_t;
   state_t state, state_nx;

   logic [awidth-1:0] cnt;
   logic              init_we, ready;
   logic [dwidth-1:0] mem [size];

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (init_we) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      if (state == INIT && cnt == last) state_nx = READY;
   end

   always_comb begin
      init_we       = (state == INIT);
      ready         = (state == READY);
      bus.init_done = ready;
   end

   // ---------------- write port ----------------
   logic              wr_ok;
   logic [bwidth-1:0] we;
   logic [awidth-1:0] wa;
   logic [dwidth-1:0] wd;

   // The clear sequence owns the write port until READY.
   always_comb begin
      wr_ok = ready && bus.wr && ({1'b0, bus.waddr} < size_w);
      we    = '0;
      wa    = bus.waddr;
      wd    = bus.din;
      if (init_we) begin
         we = '1;
         wa = cnt;
         wd = '0;
      end else if (wr_ok) begin
         we = bus.be;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < bwidth; i++)
         if (we[i]) mem[wa[iw-1:0]][8*i +: 8] <= wd[8*i +: 8];
   end

   // ---------------- read port ----------------
   logic              rd_ok, rd_in, hit, perr;
   logic [dwidth-1:0] old, rdata;

   always_comb begin
      rd_ok = ready && bus.rd;
      rd_in = ({1'b0, bus.raddr} < size_w);
      old   = mem[bus.raddr[iw-1:0]];
      hit   = (BYPASS != 0) && wr_ok && (bus.waddr == bus.raddr);
      rdata = '0;
      if (rd_in)
         for (int i = 0; i < bwidth; i++)
            rdata[8*i +: 8] = (hit && bus.be[i]) ? bus.din[8*i +: 8] : old[8*i +: 8];
   end

`ifdef MEM_PARITY_EN
   logic [bwidth-1:0] par [size];

   always_ff @(posedge clk) begin
      for (int i = 0; i < bwidth; i++)
         if (we[i]) par[wa[iw-1:0]][i] <= ^wd[8*i +: 8];
   end

   // Forwarded data is trusted; only stored entries are checked.
   always_comb begin
      perr = 1'b0;
      if (rd_in && !hit)
         for (int i = 0; i < bwidth; i++)
            perr = perr | ((^old[8*i +: 8]) ^ par[bus.raddr[iw-1:0]][i]);
   end
`else
   always_comb perr = 1'b0;
`endif

   // ---------------- output pipeline ----------------
   logic [dwidth-1:0] s1_data;
   logic              s1_vld, s1_perr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_vld  <= 1'b0;
         s1_perr <= 1'b0;
      end else begin
         s1_vld  <= rd_ok;
         s1_perr <= rd_ok && perr;
         if (rd_ok) s1_data <= rdata;
      end
   end

   generate
      if (OUT_REG == 0) begin : g_direct
         assign bus.dout     = s1_data;
         assign bus.dout_vld = s1_vld;
         assign bus.par_err  = s1_perr;
      end else begin : g_oreg
         logic [dwidth-1:0] s2_data;
         logic              s2_vld, s2_perr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_data <= '0;
               s2_vld  <= 1'b0;
               s2_perr <= 1'b0;
            end else begin
               s2_vld  <= s1_vld;
               s2_perr <= s1_perr;
               if (s1_vld) s2_data <= s1_data;
            end
         end

         assign bus.dout     = s2_data;
         assign bus.dout_vld = s2_vld;
         assign bus.par_err  = s2_perr;
      end
   endgenerate
endmodule

// File: tb/tb_mem_sdp.sv
// Scoreboard bench for mem_sdp: reads push expected data/latency, a negedge monitor pops
// and compares. Parity scenario runs only when MEM_PARITY_EN is defined.
module tb_mem_sdp;
   localparam int DW   = 32;
   localparam int AW   = 8;
   localparam int SIZE = 256;
   localparam int OREG = 0;
   localparam int BYP  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_sdp_if #(.dwidth(DW), .awidth(AW)) bus ();

   mem_sdp #(.dwidth(DW), .awidth(AW), .size(SIZE), .OUT_REG(OREG), .BYPASS(BYP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          perr;
      int            due;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [SIZE];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   bit            mon_en = 1'b1;
   logic          exp_perr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en && bus.dout_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_vld cyc=%0d dout=%h", cyc, bus.dout);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.dout !== e.data) begin
               errors++;
               $display("FAIL dout got=%h exp=%h", bus.dout, e.data);
            end
            checks++;
            if (cyc !== e.due) begin
               errors++;
               $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, e.due);
            end
            checks++;
            if (bus.par_err !== e.perr) begin
               errors++;
               $display("FAIL par_err got=%b exp=%b", bus.par_err, e.perr);
            end
         end
      end
   end

   task automatic model_clear();
      for (int a = 0; a < SIZE; a++) model[a] = '0;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic [3:0] b, input logic r, input logic [AW-1:0] ra);
      exp_t e;
      @(negedge clk);
      bus.wr = w; bus.waddr = wa; bus.din = d; bus.be = b;
      bus.rd = r; bus.raddr = ra;
      e.data = '0;
      if (r && BYP == 0) e.data = model[ra];
      if (w)
         for (int i = 0; i < 4; i++)
            if (b[i]) model[wa][8*i +: 8] = d[8*i +: 8];
      if (r && BYP != 0) e.data = model[ra];
      if (r) begin
         e.perr = exp_perr;
         e.due  = cyc + 1 + OREG;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         @(negedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      bus.wr = 1'b0; bus.waddr = '0; bus.din = '0; bus.be = '0;
      bus.rd = 1'b0; bus.raddr = '0;
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.dout !== '0) begin errors++; $display("FAIL rst_dout got=%h exp=0", bus.dout); end
      checks++; if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", bus.dout_vld); end
      checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done); end
      checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL rst_par_err got=%b exp=0", bus.par_err); end
      // Requests held active throughout the clear must be ignored.
      bus.wr = 1'b1; bus.waddr = 8'd5; bus.din = '1; bus.be = '1;
      bus.rd = 1'b1; bus.raddr = '0;
      rst_n = 1'b1;
      for (int i = 1; i <= SIZE; i++) begin
         @(negedge clk);
         checks++;
         if (bus.init_done !== (i == SIZE)) begin
            errors++;
            $display("FAIL init_done cycle=%0d got=%b exp=%b", i, bus.init_done, (i == SIZE));
         end
      end
      bus.wr = 1'b0; bus.rd = 1'b0;
   endtask

   task automatic test_clear();
      for (int a = 0; a < SIZE; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
      idle(); drain();
   endtask

   task automatic test_byte_en();
      drive(1'b1, 8'd5, 32'hAABBCCDD, 4'hF, 1'b0, '0);
      drive(1'b1, 8'd5, 32'h11223344, 4'b0101, 1'b0, '0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd5);
      drive(1'b1, 8'd5, 32'hDEADBEEF, 4'h0, 1'b0, '0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd5);
      drive(1'b1, 8'd255, 32'hC0FFEE01, 4'hF, 1'b0, '0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd255);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd0);
      idle(); drain();
   endtask

   task automatic test_bypass();
      drive(1'b1, 8'd9, 32'h12345678, 4'hF, 1'b0, '0);
      drive(1'b1, 8'd9, 32'hFFFFFFFF, 4'b0011, 1'b1, 8'd9);
      drive(1'b1, 8'd10, 32'hCAFEF00D, 4'hF, 1'b1, 8'd9);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd10);
      idle(); drain();
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 16; a++) drive(1'b1, AW'(a), DW'(a * 3), 4'hF, 1'b0, '0);
      for (int a = 0; a < 16; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
      idle(); drain();
   endtask

   task automatic test_reset_mid();
      int n;
      mon_en = 1'b0;
      @(negedge clk); bus.rd = 1'b1; bus.raddr = 8'd5;
      @(negedge clk); bus.raddr = 8'd6;
      @(posedge clk); #1;
      rst_n = 1'b0; bus.rd = 1'b0;
      #1;
      checks++; if (bus.dout !== '0) begin errors++; $display("FAIL mid_rst_dout got=%h exp=0", bus.dout); end
      checks++; if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got=%b exp=0", bus.dout_vld); end
      checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL mid_rst_init_done got=%b exp=0", bus.init_done); end
      exp_q.delete();
      model_clear();
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (bus.init_done !== 1'b1 && n < 400) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n != SIZE) begin errors++; $display("FAIL mid_rst_clear_len got=%0d exp=%0d", n, SIZE); end
      drive(1'b0, '0, '0, '0, 1'b1, 8'd5);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd9);
      idle(); drain();
   endtask

`ifdef MEM_PARITY_EN
   task automatic test_parity();
      drive(1'b1, 8'd3, 32'h0000FF00, 4'hF, 1'b0, '0);
      idle();
      @(negedge clk);
      dut.mem[3] = dut.mem[3] ^ 32'h0000_0200;
      model[3] = 32'h0000FD00;
      exp_perr = 1'b1;
      drive(1'b0, '0, '0, '0, 1'b1, 8'd3);
      exp_perr = 1'b0;
      drive(1'b1, 8'd3, 32'h0000FF00, 4'hF, 1'b0, '0);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd3);
      idle(); drain();
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d exp=finish", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clear();
      test_byte_en();
      test_bypass();
      test_back_to_back();
`ifdef MEM_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
